// File: rtl/spi_tx_seq.sv
// spi_tx_seq: frame sequencer in front of a 16-bit SPI master.
// Host words queue in a small FIFO; each word is launched with a one-cycle
// st pulse, the master's LOAD rise closes the frame and the received word is
// handed back as a one-cycle rx_vld strobe. A fixed idle gap separates frames
// and a per-frame watchdog aborts frames the master never completes.
module spi_tx_seq #(
  parameter int AW  = 2,
  parameter int GAP = 4,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic [15:0]   wr_dat,
  output logic          full,
  output logic [AW:0]   cnt,
  output logic          st,
  output logic [15:0]   MTX_DAT,
  input  logic          LOAD,
  input  logic [15:0]   MRX_DAT,
  output logic          rx_vld,
  output logic [15:0]   rx_dat,
  output logic          busy,
  output logic          tmo_err
);

  localparam int           DEPTH    = 1 << AW;
  localparam logic [AW:0]  DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [7:0]   GAP_LAST = 8'(GAP - 1);
  // Timer is compared one below TMO so the flag is visible exactly TMO
  // cycles after the st cycle.
  localparam logic [15:0]  TMO_LAST = 16'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    cnt_q;
  logic           st_q, st_d;
  logic [15:0]    mtx_q, mtx_d;
  logic           rx_vld_q, rx_vld_d;
  logic [15:0]    rx_dat_q, rx_dat_d;
  logic           tmo_q, tmo_d;
  logic [15:0]    tmr_q, tmr_d;
  logic [7:0]     gcnt_q, gcnt_d;
  logic           load_q;

  logic push, pop, rise, tmo_hit;

  assign full    = (cnt_q == DEPTH_C);
  assign push    = wr_en & ~full;
  // Head word leaves the FIFO in the IDLE cycle that launches it.
  assign pop     = (state_q == S_IDLE) && (cnt_q != '0);
  assign rise    = LOAD & ~load_q;
  assign tmo_hit = (tmr_q == TMO_LAST);

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_dat;
  end

  // FIFO pointers and occupancy; a full-cycle write is dropped even if a pop
  // happens in the same cycle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Sequencer state, frame outputs, watchdog and gap counters.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      st_q     <= 1'b0;
      mtx_q    <= '0;
      rx_vld_q <= 1'b0;
      rx_dat_q <= '0;
      tmo_q    <= 1'b0;
      tmr_q    <= '0;
      gcnt_q   <= '0;
      load_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      mtx_q    <= mtx_d;
      rx_vld_q <= rx_vld_d;
      rx_dat_q <= rx_dat_d;
      tmo_q    <= tmo_d;
      tmr_q    <= tmr_d;
      gcnt_q   <= gcnt_d;
      load_q   <= LOAD;
    end
  end

  // Next-state logic: launch, wait for the master's LOAD low/high handshake,
  // abort on watchdog (a rise in the same cycle takes priority), then gap.
  always_comb begin
    state_d  = state_q;
    st_d     = 1'b0;
    mtx_d    = mtx_q;
    rx_vld_d = 1'b0;
    rx_dat_d = rx_dat_q;
    tmo_d    = tmo_q;
    tmr_d    = tmr_q;
    gcnt_d   = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          st_d    = 1'b1;
          mtx_d   = mem_q[rptr_q];
          tmr_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tmr_d = tmr_q + 16'd1;
        if (tmo_hit) begin
          tmo_d   = 1'b1;
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO, S_WAIT_HI: begin
        tmr_d = tmr_q + 16'd1;
        if (rise) begin
          // Also covers a frame so short that LOAD rose before WAIT_HI.
          rx_dat_d = MRX_DAT;
          rx_vld_d = 1'b1;
          gcnt_d   = '0;
          state_d  = S_GAP;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          gcnt_d  = '0;
          state_d = S_GAP;
        end else if (state_q == S_WAIT_LO && !LOAD) begin
          state_d = S_WAIT_HI;
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 8'd1;
        if (gcnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt     = cnt_q;
  assign st      = st_q;
  assign MTX_DAT = mtx_q;
  assign rx_vld  = rx_vld_q;
  assign rx_dat  = rx_dat_q;
  assign busy    = (state_q != S_IDLE);
  assign tmo_err = tmo_q;

endmodule
